counter_nbit: RTL and testbench

COUNTER_NBIT -- requirements
Module: counter_nbit

---
 rtl/counter_pkg.sv | 14 +
 rtl/counter_nbit_if.sv | 21 ++
 rtl/counter_prescaler.sv | 29 ++
 rtl/counter_nbit.sv | 87 ++++++++
 tb/tb_counter_nbit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: direction/boundary-mode constants and a clog2 helper shared by the counter files.
package counter_pkg;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction
endpackage

// File: rtl/counter_nbit_if.sv
// counter_nbit_if: control and status bundle of counter_nbit.
//   master drives en/up/sat/clear/load/load_val/ovf_clr and observes count/tc/ovf/unf;
//   slave (the counter) is the mirror image.
interface counter_nbit_if #(parameter int WIDTH = 8);
    logic             en;
    logic             up;
    logic             sat;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             ovf_clr;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;
    logic             unf;

    modport master (output en, up, sat, clear, load, load_val, ovf_clr,
                    input  count, tc, ovf, unf);
    modport slave  (input  en, up, sat, clear, load, load_val, ovf_clr,
                    output count, tc, ovf, unf);
endinterface

// File: rtl/counter_prescaler.sv
// counter_prescaler: divides enabled clock edges by PRESCALE.
//   clk, reset (async active-low), en (advance phase), restart (phase back to 0),
//   tick (high on the enabled edge that completes a PRESCALE-edge period).
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic tick
);
    localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    assign tick = en && (phase == LAST);

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            phase <= '0;
        else if (restart)
            phase <= '0;
        else if (en)
            phase <= tick ? '0 : phase + 1'b1;
endmodule

// File: rtl/counter_nbit.sv
// counter_nbit: up/down counter over 0..MAX_VAL with prescaler, wrap/saturate and sticky flags.
//   clk, reset (async active-low), bus (counter_nbit_if.slave: controls in, count/tc/ovf/unf out).
module counter_nbit
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 8,
    parameter longint MAX_VAL  = (longint'(1) << WIDTH) - 1,
    parameter int     PRESCALE = 1
) (
    input  logic               clk,
    input  logic               reset,
    counter_nbit_if.slave      bus
);
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("counter_nbit: WIDTH must be 2..32");
    end
    if (MAX_VAL < 0 || MAX_VAL >= (longint'(1) << WIDTH)) begin : g_bad_max
        $error("counter_nbit: MAX_VAL must lie in 0..2**WIDTH-1");
    end
    if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
        $error("counter_nbit: PRESCALE must be 1..256");
    end

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

    logic             tick;
    logic             restart;
    logic             step;
    logic             at_max;
    logic             at_zero;
    logic             ovf_hit;
    logic             unf_hit;
    logic [WIDTH-1:0] load_sat;
    logic [WIDTH-1:0] up_val;
    logic [WIDTH-1:0] dn_val;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic             ovf_q;
    logic             unf_q;

    // clear and load both realign the prescaler so the next step is a full period away
    assign restart = bus.clear | bus.load;

    counter_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk     (clk),
        .reset   (reset),
        .en      (bus.en),
        .restart (restart),
        .tick    (tick)
    );

    // boundary cases are selected before any +1/-1 result can be used, so count never leaves 0..MAX
    always_comb begin
        at_max   = count_q == MAX;
        at_zero  = count_q == '0;
        step     = tick & ~restart;
        ovf_hit  = step & (bus.up == DIR_UP) & at_max;
        unf_hit  = step & (bus.up == DIR_DOWN) & at_zero;
        load_sat = (bus.load_val > MAX) ? MAX : bus.load_val;
        up_val   = at_max ? ((bus.sat == MODE_SAT) ? MAX : '0) : count_q + 1'b1;
        dn_val   = at_zero ? ((bus.sat == MODE_SAT) ? '0 : MAX) : count_q - 1'b1;
        count_d  = bus.clear ? '0 :
                   bus.load  ? load_sat :
                   step      ? ((bus.up == DIR_UP) ? up_val : dn_val) :
                               count_q;
    end

    // a boundary event on the same edge as ovf_clr keeps its flag set
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= ovf_hit | unf_hit;
            ovf_q   <= ovf_hit | (ovf_q & ~bus.ovf_clr);
            unf_q   <= unf_hit | (unf_q & ~bus.ovf_clr);
        end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
endmodule

// File: tb/tb_counter_nbit.sv
// tb_counter_nbit: directed bench for counter_nbit (WIDTH=4, MAX_VAL=9) with PRESCALE=1 and PRESCALE=3 instances.
module tb_counter_nbit;
    localparam int MAXV = 9;

    typedef struct {
        int cnt;
        int ph;
        bit tc;
        bit ovf;
        bit unf;
    } mstate_t;

    logic       clk;
    logic       reset;
    logic       en, up, sat, clr, ld, oc;
    logic [3:0] lv;
    int         checks = 0;
    int         passed = 0;
    mstate_t    ma = '{default: 0};
    mstate_t    mb = '{default: 0};

    counter_nbit_if #(.WIDTH(4)) ia ();
    counter_nbit_if #(.WIDTH(4)) ib ();

    assign ia.en = en;   assign ib.en = en;
    assign ia.up = up;   assign ib.up = up;
    assign ia.sat = sat; assign ib.sat = sat;
    assign ia.clear = clr; assign ib.clear = clr;
    assign ia.load = ld; assign ib.load = ld;
    assign ia.load_val = lv; assign ib.load_val = lv;
    assign ia.ovf_clr = oc; assign ib.ovf_clr = oc;

    counter_nbit #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) dut (.clk(clk), .reset(reset), .bus(ia));
    counter_nbit #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) dut3 (.clk(clk), .reset(reset), .bus(ib));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference: the prescaler is "enabled edges since the last restart, modulo p";
    // a step is a signed +/-1 that is then wrapped modulo MAXV+1 or clamped to 0..MAXV.
    function automatic mstate_t model_next(input mstate_t s, input int p);
        mstate_t n;
        bit      hit_o;
        bit      hit_u;
        int      t;
        n = s;
        hit_o = 0;
        hit_u = 0;
        if (clr) begin
            n.cnt = 0;
            n.ph = 0;
        end else if (ld) begin
            n.cnt = (int'(lv) > MAXV) ? MAXV : int'(lv);
            n.ph = 0;
        end else if (en) begin
            n.ph = (s.ph + 1) % p;
            if (s.ph == p - 1) begin
                t = up ? s.cnt + 1 : s.cnt - 1;
                hit_o = t > MAXV;
                hit_u = t < 0;
                if (sat) n.cnt = (t > MAXV) ? MAXV : ((t < 0) ? 0 : t);
                else n.cnt = (t + MAXV + 1) % (MAXV + 1);
            end
        end
        n.tc = hit_o | hit_u;
        n.ovf = hit_o | (s.ovf & ~oc);
        n.unf = hit_u | (s.unf & ~oc);
        return n;
    endfunction

    always @(posedge clk or negedge reset)
        if (!reset) begin
            ma <= '{default: 0};
            mb <= '{default: 0};
        end else begin
            ma <= model_next(ma, 1);
            mb <= model_next(mb, 3);
        end

    always @(negedge clk) begin
        cmp("a.count", int'(ia.count), ma.cnt);
        cmp("a.tc", int'(ia.tc), int'(ma.tc));
        cmp("a.ovf", int'(ia.ovf), int'(ma.ovf));
        cmp("a.unf", int'(ia.unf), int'(ma.unf));
        cmp("b.count", int'(ib.count), mb.cnt);
        cmp("b.tc", int'(ib.tc), int'(mb.tc));
        cmp("b.ovf", int'(ib.ovf), int'(mb.ovf));
        cmp("b.unf", int'(ib.unf), int'(mb.unf));
    end

    initial begin
        int dn_exp[4] = '{1, 0, 9, 8};
        int dn_tc[4]  = '{0, 0, 1, 0};
        {en, up, sat, clr, ld, oc} = '0;
        lv = '0;
        reset = 1'b0;
        cyc(2);
        cmp("rst_count", int'(ia.count), 0);
        cmp("rst_ovf", int'(ia.ovf), 0);
        reset = 1'b1;
        cyc(1);
        en = 1'b1;
        up = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            cyc(1);
            cmp("up_wrap_count", int'(ia.count), k % 10);
            if (k == 10) begin
                cmp("wrap_tc", int'(ia.tc), 1);
                cmp("wrap_ovf", int'(ia.ovf), 1);
            end else if (k >= 9) cmp("no_tc", int'(ia.tc), 0);
        end
        en = 1'b0;
        lv = 4'd2;
        ld = 1'b1;
        cyc(1);
        cmp("load2", int'(ia.count), 2);
        ld = 1'b0;
        up = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            cmp("down_count", int'(ia.count), dn_exp[k]);
            cmp("down_tc", int'(ia.tc), dn_tc[k]);
        end
        cmp("down_unf", int'(ia.unf), 1);
        en = 1'b0;
        oc = 1'b1;
        cyc(1);
        cmp("clr_ovf", int'(ia.ovf), 0);
        cmp("clr_unf", int'(ia.unf), 0);
        oc = 1'b0;
        lv = 4'd8;
        ld = 1'b1;
        cyc(1);
        cmp("load8", int'(ia.count), 8);
        ld = 1'b0;
        up = 1'b1;
        sat = 1'b1;
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            cmp("sat_count", int'(ia.count), 9);
            cmp("sat_tc", int'(ia.tc), (k > 0) ? 1 : 0);
        end
        cmp("sat_ovf", int'(ia.ovf), 1);
        oc = 1'b1;
        cyc(1);
        cmp("event_beats_clr", int'(ia.ovf), 1);
        en = 1'b0;
        cyc(1);
        cmp("ovf_cleared", int'(ia.ovf), 0);
        oc = 1'b0;
        lv = 4'd15;
        ld = 1'b1;
        cyc(1);
        cmp("load15_clamp", int'(ia.count), 9);
        clr = 1'b1;
        lv = 4'd3;
        cyc(1);
        cmp("clear_over_load", int'(ia.count), 0);
        clr = 1'b0;
        ld = 1'b0;
        sat = 1'b0;
        en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            cyc(1);
            cmp("pre3_count", int'(ib.count), k / 3);
        end
        cyc(1);
        cmp("pre3_phase1", int'(ib.count), 3);
        en = 1'b0;
        cyc(2);
        cmp("pre3_hold", int'(ib.count), 3);
        en = 1'b1;
        cyc(1);
        cmp("pre3_delayed", int'(ib.count), 3);
        cyc(1);
        cmp("pre3_step", int'(ib.count), 4);
        en = 1'b0;
        lv = 4'd9;
        ld = 1'b1;
        cyc(1);
        ld = 1'b0;
        en = 1'b1;
        cyc(1);
        cmp("pre_rst_ovf", int'(ia.ovf), 1);
        lv = 4'd5;
        ld = 1'b1;
        en = 1'b0;
        cyc(1);
        cmp("load5", int'(ia.count), 5);
        ld = 1'b0;
        en = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        cmp("async_count", int'(ia.count), 0);
        cmp("async_tc", int'(ia.tc), 0);
        cmp("async_ovf", int'(ia.ovf), 0);
        cmp("async_unf", int'(ia.unf), 0);
        cmp("async_b_count", int'(ib.count), 0);
        @(negedge clk);
        reset = 1'b1;
        en = 1'b0;
        cyc(1);
        cmp("release_tc", int'(ia.tc), 0);
        en = 1'b1;
        cyc(3);
        cmp("post_rst_a", int'(ia.count), 3);
        cmp("post_rst_b", int'(ib.count), 1);
        en = 1'b0;
        cyc(1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
